// File: rtl/pdm_decimator.sv
// PDM decimator: counts ones over a DECIM-cycle window, scales to a 10-bit code
// and queues it in a small FIFO. Define PDM_DECIM_DROP_CNT_EN to add drop_count.
module pdm_decimator #(
  parameter int DECIM = 2500,
  parameter int SCALE = 26818,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdm_in,
  output logic [9:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overrun,
  input  logic       overrun_clr
`ifdef PDM_DECIM_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [11:0] WLAST   = 12'(DECIM - 1);
  localparam logic [15:0] SCALE_W = 16'(SCALE);

  // Synchronizer and window accumulation
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] ones_q, ones_d;
  logic        v1_q, v1_d;
  logic [11:0] prod_hi_q, prod_hi_d;
  logic        v2_q, v2_d;
  logic        win_last;
  logic [9:0]  code_next;

  // Output FIFO
  logic [9:0]  mem_q [DEPTH];
  logic [9:0]  mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        overrun_q, overrun_d;
  logic        fifo_empty, fifo_full;
  logic        pop, push, drop;

  always_comb begin
    sync1_d  = pdm_in;
    sync2_d  = sync1_q;
    win_last = (wcnt_q == WLAST);
    wcnt_d   = win_last ? 12'd0 : wcnt_q + 12'd1;
    // The bit seen on the closing cycle belongs to the window being closed.
    acc_d    = win_last ? 12'd0 : acc_q + {11'd0, sync2_q};
    ones_d   = win_last ? acc_q + {11'd0, sync2_q} : ones_q;
    v1_d     = win_last;
    // Only the integer part of the Q0.16 product is kept.
    prod_hi_d = v1_q ? 12'((28'(ones_q) * 28'(SCALE_W)) >> 16) : prod_hi_q;
    v2_d      = v1_q;
    code_next = (prod_hi_q[11:10] != 2'b00) ? 10'h3FF : prod_hi_q[9:0];
  end

  // Handshake: the head entry is transferred on a clk edge where code_valid and
  // code_ready are both high; code holds steady while code_valid & ~code_ready.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    pop        = ~fifo_empty & code_ready;
    push       = v2_q & (~fifo_full | pop);
    drop       = v2_q & fifo_full & ~pop;
    rptr_d     = rptr_q + (AW+1)'(pop);
    wptr_d     = wptr_q + (AW+1)'(push);
    mem_d      = mem_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = code_next;
    end
    // A drop in the same cycle as a clear leaves the flag set.
    overrun_d  = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    code       = fifo_empty ? 10'd0 : mem_q[rptr_q[AW-1:0]];
    code_valid = ~fifo_empty;
    overrun    = overrun_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      wcnt_q    <= 12'd0;
      acc_q     <= 12'd0;
      ones_q    <= 12'd0;
      v1_q      <= 1'b0;
      prod_hi_q <= 12'd0;
      v2_q      <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      ones_q    <= ones_d;
      v1_q      <= v1_d;
      prod_hi_q <= prod_hi_d;
      v2_q      <= v2_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef PDM_DECIM_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overrun_clr) begin
      drop_cnt_d = 8'd0;
    end
    if (drop) begin
      if (overrun_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
    drop_count = drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: table of stream patterns plus hand-written FIFO,
// overrun and reset sequences, checked against a window-sum reference model.
module tb_pdm_decimator;

  localparam int DECIM = 2500;
  localparam int SCALE = 26818;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pdm_in = 1'b0;
  logic       code_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [9:0] code;
  logic       code_valid;
  logic       overrun;
`ifdef PDM_DECIM_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  pdm_decimator #(.DECIM(DECIM), .SCALE(SCALE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_in     (pdm_in),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef PDM_DECIM_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    int mode;      // 0 zeros, 1 ones, 2 alternating, 3 random density, 4 step
    int rmode;     // 0 never ready, 1 always, 2 random, 3 single pulse
    int nwin;
    int exp_last;  // expected code of the last window
  } vec_t;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc;
  int         first_valid;
  int         dens;
  int         pulse_cyc;
  bit         bits_q[$];
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  vec_t       vecs[4];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: bit driven for cycle n reaches the counter on edge n+3; window w
  // spans edges w*DECIM+1 .. (w+1)*DECIM.
  function automatic int model_code(input int w);
    longint ones = 0;
    longint p;
    for (int m = w * DECIM + 1; m <= (w + 1) * DECIM; m++) begin
      if (m - 3 >= 0 && m - 3 < bits_q.size()) ones += longint'(bits_q[m - 3]);
    end
    p = (ones * SCALE) / 65536;
    if (p > 1023) p = 1023;
    return int'(p);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pdm_in = 1'b0;
    code_ready = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    first_valid = -1;
    bits_q.delete();
    got_q.delete();
  endtask

  // Driver: one iteration per cycle, inputs set at the negedge before edge cyc+1.
  task automatic run_cycles(input int n, input int mode, input int rmode);
    for (int i = 0; i < n; i++) begin
      bit b;
      case (mode)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (cyc % 2 == 0);
        3: begin
          if (cyc % DECIM == 0) dens = $urandom_range(0, 100);
          b = ($urandom_range(0, 99) < dens);
        end
        default: b = (cyc >= DECIM - 3);
      endcase
      pdm_in = b;
      bits_q.push_back(b);
      case (rmode)
        0: code_ready = 1'b0;
        1: code_ready = 1'b1;
        2: code_ready = 1'($urandom_range(0, 1));
        default: code_ready = (cyc == pulse_cyc);
      endcase
      if (code_valid && first_valid < 0) first_valid = cyc;
      if (code_valid && code_ready) got_q.push_back(code);
      @(negedge clk);
      cyc++;
    end
  endtask

  // Scoreboard: compare popped codes with model windows first_w .. first_w+nw-1.
  task automatic compare_codes(input string name, input int first_w, input int nw);
    int n;
    exp_q.delete();
    for (int w = first_w; w < first_w + nw; w++) exp_q.push_back(10'(model_code(w)));
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(name, int'(got_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1, 3, 0};
    vecs[1] = '{1, 1, 3, 1023};
    vecs[2] = '{2, 2, 2, 511};
    vecs[3] = '{4, 1, 2, 1023};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_code", code, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_overrun", overrun, 0);
`ifdef PDM_DECIM_DROP_CNT_EN
    check("rst_drop_count", drop_count, 0);
`endif

    // Steady-state patterns
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_cycles(vecs[i].nwin * DECIM + 40, vecs[i].mode, vecs[i].rmode);
      compare_codes($sformatf("vec%0d_code", i), 0, vecs[i].nwin);
      check($sformatf("vec%0d_last", i),
            (got_q.size() > 0) ? int'(got_q[got_q.size() - 1]) : -1, vecs[i].exp_last);
      check($sformatf("vec%0d_first_valid", i), first_valid, DECIM + 2);
      check($sformatf("vec%0d_overrun", i), overrun, 0);
    end
    // The step lands on the closing bit: one counted one rounds down to 0.
    check("step_first_code", (got_q.size() > 0) ? int'(got_q[0]) : -1, 0);

    // Consumer stalled for six windows: four kept in order, two dropped
    do_reset();
    run_cycles(6 * DECIM + 6, 3, 0);
    check("stall_overrun", overrun, 1);
`ifdef PDM_DECIM_DROP_CNT_EN
    check("stall_drop_count", drop_count, 2);
`endif
    run_cycles(10, 3, 1);
    compare_codes("stall_order", 0, 4);
    check("stall_drained", code_valid, 0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("clr_overrun", overrun, 0);
`ifdef PDM_DECIM_DROP_CNT_EN
    check("clr_drop_count", drop_count, 0);
`endif

    // Full FIFO with a pop on the exact push edge: nothing dropped
    do_reset();
    pulse_cyc = 5 * DECIM + 1;
    run_cycles(5 * DECIM + 6, 3, 3);
    check("fullpop_overrun", overrun, 0);
    check("fullpop_one_popped", got_q.size(), 1);
    run_cycles(10, 3, 1);
    compare_codes("fullpop_code", 0, 5);
    check("fullpop_overrun_after", overrun, 0);

    // Asynchronous reset mid-window with two entries queued
    do_reset();
    run_cycles(2 * DECIM + 6 + DECIM / 2, 3, 0);
    check("midrst_queued", code_valid, 1);
    #3 rst = 1'b0;
    #1;
    check("midrst_code_valid", code_valid, 0);
    check("midrst_code", code, 0);
    do_reset();
    run_cycles(DECIM + 20, 3, 1);
    compare_codes("midrst_fresh", 0, 1);
    check("midrst_first_valid", first_valid, DECIM + 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
